vertex_xform_seq: RTL and testbench

Parametrised fixed-point vertex transform engine for the renderer geometry path. It computes one vertex per request as newv = M·v + T, using a programmable 3×3 matrix M and a translation vector T. It generalises the single-vertex `x,y,z → newx,newy,newz` STARTER/DONE engine in three ways: width and fraction parameters, a loadable matrix and translation, and optional saturation. A single shared multiplier keeps the area small for FPGA builds.

---
 rtl/vertex_xform_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_vertex_xform_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_xform_seq.sv
// ---------------------------------------------------------------------------
// vertex_xform_seq
//   Fixed-point vertex transform: newv = M * v + T. M is a programmable 3x3
//   matrix and T a translation vector, both in Q(WIDTH-FRAC).FRAC. One
//   shared multiplier walks the matrix one coefficient per cycle, so a
//   vertex takes 13 cycles from the accepting edge to DONE.
//
//   State table:
//     state   | meaning
//     IDLE    | waiting for STARTER; coefficient writes accepted
//     ROW     | row r, cycle c: c=0..2 multiply-accumulate, c=3 finish row
//     FIN     | publish row registers to newx/newy/newz, pulse DONE
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   STARTER           request, sampled only while BUSY=0
//   x, y, z           input vertex, captured on the accepting edge
//   M_WE/ADDR/DATA    coefficient write: 0-8 m00..m22, 9-11 tx..tz
//   BUSY, DONE        computation in progress, one-cycle result strobe
//   newx/newy/newz    transformed vertex, held until the next DONE
// ---------------------------------------------------------------------------
module vertex_xform_seq #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STARTER,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic             M_WE,
    input  logic [3:0]       M_ADDR,
    input  logic [WIDTH-1:0] M_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] newx,
    output logic [WIDTH-1:0] newy,
    output logic [WIDTH-1:0] newz
);

    localparam int ACCW = 2 * WIDTH + 2;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1) << FRAC;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ROW  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]             state;
    logic [1:0]             r;
    logic [1:0]             c;
    logic [WIDTH-1:0]       m [9];
    logic [WIDTH-1:0]       t [3];
    logic [WIDTH-1:0]       v [3];
    logic [WIDTH-1:0]       rowreg [3];
    logic signed [ACCW-1:0] acc;

    // A write landing on the accepting edge is parked here and applied in
    // FIN, so the vertex just accepted still sees the old coefficient.
    logic                   pend_we;
    logic [3:0]             pend_addr;
    logic [WIDTH-1:0]       pend_data;

    logic                   accept;
    logic                   wr_ok;
    logic                   wr_en;
    logic [3:0]             wr_addr;
    logic [WIDTH-1:0]       wr_data;

    logic signed [WIDTH-1:0]   coef;
    logic signed [WIDTH-1:0]   vsel;
    logic signed [WIDTH-1:0]   tsel;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0]    prod_ext;
    logic signed [ACCW-1:0]    t_ext;
    logic signed [ACCW-1:0]    sum;
    logic signed [ACCW-1:0]    shifted;
    logic                      ovf;
    logic [WIDTH-1:0]          row_val;

    assign accept = (state == ST_IDLE) && STARTER;
    assign wr_ok  = M_WE && !BUSY && (M_ADDR <= 4'd11);

    always_comb begin
        coef = '0;
        vsel = '0;
        tsel = '0;
        case ({r, c})
            4'b0000: coef = m[0];
            4'b0001: coef = m[1];
            4'b0010: coef = m[2];
            4'b0100: coef = m[3];
            4'b0101: coef = m[4];
            4'b0110: coef = m[5];
            4'b1000: coef = m[6];
            4'b1001: coef = m[7];
            4'b1010: coef = m[8];
            default: coef = '0;
        endcase
        case (c)
            2'd0:    vsel = v[0];
            2'd1:    vsel = v[1];
            2'd2:    vsel = v[2];
            default: vsel = '0;
        endcase
        case (r)
            2'd0:    tsel = t[0];
            2'd1:    tsel = t[1];
            2'd2:    tsel = t[2];
            default: tsel = '0;
        endcase
    end

    assign prod     = coef * vsel;
    assign prod_ext = {{2{prod[2*WIDTH-1]}}, prod};
    assign t_ext    = {{(ACCW-WIDTH){tsel[WIDTH-1]}}, tsel};
    assign sum      = acc + (t_ext <<< FRAC);
    assign shifted  = sum >>> FRAC;

    // Result fits only if every bit above the WIDTH sign bit matches it.
    assign ovf = !((&shifted[ACCW-1:WIDTH-1]) || !(|shifted[ACCW-1:WIDTH-1]));

    always_comb begin
        row_val = shifted[WIDTH-1:0];
        if (SATURATE && ovf) begin
            row_val = shifted[ACCW-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = M_ADDR;
        wr_data = M_DATA;
        if (state == ST_FIN && pend_we) begin
            wr_en   = 1'b1;
            wr_addr = pend_addr;
            wr_data = pend_data;
        end else if (wr_ok && !accept) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 9; i++) begin
                m[i] <= (i == 0 || i == 4 || i == 8) ? ONE : '0;
            end
            for (int i = 0; i < 3; i++) begin
                t[i] <= '0;
            end
            pend_we   <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (wr_en && wr_addr == 4'(i)) m[i] <= wr_data;
            end
            for (int i = 0; i < 3; i++) begin
                if (wr_en && wr_addr == 4'(i + 9)) t[i] <= wr_data;
            end
            if (wr_ok && accept) begin
                pend_we   <= 1'b1;
                pend_addr <= M_ADDR;
                pend_data <= M_DATA;
            end else if (state == ST_FIN) begin
                pend_we <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            r     <= '0;
            c     <= '0;
            acc   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            newx  <= '0;
            newy  <= '0;
            newz  <= '0;
            for (int i = 0; i < 3; i++) begin
                v[i]      <= '0;
                rowreg[i] <= '0;
            end
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (STARTER) begin
                        v[0]  <= x;
                        v[1]  <= y;
                        v[2]  <= z;
                        acc   <= '0;
                        r     <= '0;
                        c     <= '0;
                        BUSY  <= 1'b1;
                        state <= ST_ROW;
                    end
                end
                ST_ROW: begin
                    if (c != 2'd3) begin
                        acc <= acc + prod_ext;
                        c   <= c + 2'd1;
                    end else begin
                        rowreg[r] <= row_val;
                        acc       <= '0;
                        c         <= '0;
                        if (r == 2'd2) begin
                            state <= ST_FIN;
                        end else begin
                            r <= r + 2'd1;
                        end
                    end
                end
                ST_FIN: begin
                    newx  <= rowreg[0];
                    newy  <= rowreg[1];
                    newz  <= rowreg[2];
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vertex_xform_seq.sv
// ---------------------------------------------------------------------------
// tb_vertex_xform_seq
//   Bench for vertex_xform_seq. Two instances share all inputs: one
//   saturating, one wrapping. Expected results are queued when a vertex is
//   started and checked against both instances when DONE appears.
// ---------------------------------------------------------------------------
module tb_vertex_xform_seq;

    localparam int W = 32;
    localparam logic [W-1:0] ONE = 32'h0001_0000;

    typedef logic [11:0][W-1:0] coefs_t;

    typedef struct {
        coefs_t           coef;
        logic [W-1:0]     vx, vy, vz;
        logic [W-1:0]     ex, ey, ez;
        logic [W-1:0]     wx, wy, wz;
    } vec_t;

    typedef struct {
        logic [W-1:0] ex, ey, ez;
        logic [W-1:0] wx, wy, wz;
        int           done_cyc;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         STARTER;
    logic [W-1:0] x, y, z;
    logic         M_WE;
    logic [3:0]   M_ADDR;
    logic [W-1:0] M_DATA;

    logic         busy_s, done_s, busy_w, done_w;
    logic [W-1:0] newx_s, newy_s, newz_s;
    logic [W-1:0] newx_w, newy_w, newz_w;

    vertex_xform_seq #(.WIDTH(W), .FRAC(16), .SATURATE(1'b1)) dut_sat (
        .CLK(CLK), .RESET(RESET), .STARTER(STARTER),
        .x(x), .y(y), .z(z),
        .M_WE(M_WE), .M_ADDR(M_ADDR), .M_DATA(M_DATA),
        .BUSY(busy_s), .DONE(done_s),
        .newx(newx_s), .newy(newy_s), .newz(newz_s)
    );

    vertex_xform_seq #(.WIDTH(W), .FRAC(16), .SATURATE(1'b0)) dut_wrap (
        .CLK(CLK), .RESET(RESET), .STARTER(STARTER),
        .x(x), .y(y), .z(z),
        .M_WE(M_WE), .M_ADDR(M_ADDR), .M_DATA(M_DATA),
        .BUSY(busy_w), .DONE(done_w),
        .newx(newx_w), .newy(newy_w), .newz(newz_w)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];
    vec_t tbl[5];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Output monitor / scoreboard
    exp_t         mon_e;
    int           busy_run = 0;
    logic [W-1:0] held_sx = '0, held_sy = '0, held_sz = '0;
    logic [W-1:0] held_wx = '0, held_wy = '0, held_wz = '0;

    always @(negedge CLK) begin
        if (RESET) begin
            busy_run = 0;
            held_sx = '0; held_sy = '0; held_sz = '0;
            held_wx = '0; held_wy = '0; held_wz = '0;
        end else begin
            if (busy_s) busy_run++;
            if (done_s) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 (cyc=%0d)", cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("done_cycle", W'(cyc), W'(mon_e.done_cyc));
                    chk("busy_len", W'(busy_run), 32'd13);
                    chk("sat_newx", newx_s, mon_e.ex);
                    chk("sat_newy", newy_s, mon_e.ey);
                    chk("sat_newz", newz_s, mon_e.ez);
                    chk("wrap_done", W'(done_w), 32'd1);
                    chk("wrap_newx", newx_w, mon_e.wx);
                    chk("wrap_newy", newy_w, mon_e.wy);
                    chk("wrap_newz", newz_w, mon_e.wz);
                    held_sx = mon_e.ex; held_sy = mon_e.ey; held_sz = mon_e.ez;
                    held_wx = mon_e.wx; held_wy = mon_e.wy; held_wz = mon_e.wz;
                end
                busy_run = 0;
            end else begin
                chk("wrap_done_idle", W'(done_w), 32'd0);
                chk("hold_sat_x", newx_s, held_sx);
                chk("hold_sat_y", newy_s, held_sy);
                chk("hold_sat_z", newz_s, held_sz);
                chk("hold_wrap_x", newx_w, held_wx);
                chk("hold_wrap_y", newy_w, held_wy);
                chk("hold_wrap_z", newz_w, held_wz);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_coef(input logic [3:0] addr, input logic [W-1:0] data);
        M_WE   = 1'b1;
        M_ADDR = addr;
        M_DATA = data;
        tick();
        M_WE   = 1'b0;
    endtask

    task automatic start_vec(input logic [W-1:0] vx, input logic [W-1:0] vy, input logic [W-1:0] vz,
                             input logic [W-1:0] ex, input logic [W-1:0] ey, input logic [W-1:0] ez,
                             input logic [W-1:0] wx, input logic [W-1:0] wy, input logic [W-1:0] wz,
                             input bit push, input bit we, input logic [3:0] wa, input logic [W-1:0] wd);
        exp_t e;
        STARTER = 1'b1;
        x = vx; y = vy; z = vz;
        M_WE = we; M_ADDR = wa; M_DATA = wd;
        e.ex = ex; e.ey = ey; e.ez = ez;
        e.wx = wx; e.wy = wy; e.wz = wz;
        e.done_cyc = cyc + 14;
        if (push) sbq.push_back(e);
        tick();
        STARTER = 1'b0;
        M_WE = 1'b0;
        x = $urandom; y = $urandom; z = $urandom;
    endtask

    task automatic wait_done(input int maxc, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            tick();
            if (done_s) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done within %0d cycles", tag, maxc);
        end
    endtask

    function automatic coefs_t ident();
        coefs_t k = '0;
        k[0] = ONE;
        k[4] = ONE;
        k[8] = ONE;
        return k;
    endfunction

    task automatic load_all(input coefs_t k);
        for (int a = 0; a < 12; a++) write_coef(4'(a), k[a]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // rotation 90 deg about z plus tx = 5
        tbl[0].coef     = '0;
        tbl[0].coef[1]  = 32'hFFFF_0000;
        tbl[0].coef[3]  = 32'h0001_0000;
        tbl[0].coef[8]  = 32'h0001_0000;
        tbl[0].coef[9]  = 32'h0005_0000;
        tbl[0].vx = 32'h0001_0000; tbl[0].vy = 32'h0; tbl[0].vz = 32'h0002_0000;
        tbl[0].ex = 32'h0005_0000; tbl[0].ey = 32'h0001_0000; tbl[0].ez = 32'h0002_0000;
        // floor rounding: 0.5 * -2^-16
        tbl[1].coef     = ident();
        tbl[1].coef[0]  = 32'h0000_8000;
        tbl[1].vx = 32'hFFFF_FFFF; tbl[1].vy = 32'h0; tbl[1].vz = 32'h0;
        tbl[1].ex = 32'hFFFF_FFFF; tbl[1].ey = 32'h0; tbl[1].ez = 32'h0;
        // positive overflow
        tbl[2].coef     = ident();
        tbl[2].coef[0]  = 32'h7FFF_FFFF;
        tbl[2].vx = 32'h7FFF_FFFF; tbl[2].vy = 32'h0; tbl[2].vz = 32'h0;
        tbl[2].ex = 32'h7FFF_FFFF; tbl[2].ey = 32'h0; tbl[2].ez = 32'h0;
        // negative overflow
        tbl[3].coef     = ident();
        tbl[3].coef[0]  = 32'h7FFF_FFFF;
        tbl[3].vx = 32'h8000_0000; tbl[3].vy = 32'h0; tbl[3].vz = 32'h0;
        tbl[3].ex = 32'h8000_0000; tbl[3].ey = 32'h0; tbl[3].ez = 32'h0;
        // general: M=[[2,0,0],[0,.5,0],[1,1,1]], T=(-1,.25,3), v=(3,-3,1.5)
        tbl[4].coef     = '0;
        tbl[4].coef[0]  = 32'h0002_0000;
        tbl[4].coef[4]  = 32'h0000_8000;
        tbl[4].coef[6]  = 32'h0001_0000;
        tbl[4].coef[7]  = 32'h0001_0000;
        tbl[4].coef[8]  = 32'h0001_0000;
        tbl[4].coef[9]  = 32'hFFFF_0000;
        tbl[4].coef[10] = 32'h0000_4000;
        tbl[4].coef[11] = 32'h0003_0000;
        tbl[4].vx = 32'h0003_0000; tbl[4].vy = 32'hFFFD_0000; tbl[4].vz = 32'h0001_8000;
        tbl[4].ex = 32'h0005_0000; tbl[4].ey = 32'hFFFE_C000; tbl[4].ez = 32'h0004_8000;
        for (int i = 0; i < 5; i++) begin
            tbl[i].wx = tbl[i].ex; tbl[i].wy = tbl[i].ey; tbl[i].wz = tbl[i].ez;
        end
        tbl[2].wx = 32'hFFFF_0000;
        tbl[3].wx = 32'h0000_8000;

        RESET = 1'b1; STARTER = 1'b0; M_WE = 1'b0; M_ADDR = '0; M_DATA = '0;
        x = '0; y = '0; z = '0;
        repeat (3) tick();
        RESET = 1'b0;
        tick();
        chk("rst_busy", W'(busy_s), 32'd0);
        chk("rst_done", W'(done_s), 32'd0);
        chk("rst_newx", newx_s, 32'd0);
        chk("rst_newy", newy_s, 32'd0);
        chk("rst_newz", newz_s, 32'd0);

        // identity from reset
        start_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                  32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                  32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b1, 1'b0, 4'd0, '0);
        wait_done(20, "identity");

        for (int i = 0; i < 5; i++) begin
            load_all(tbl[i].coef);
            write_coef(4'(12 + i % 4), 32'hDEAD_BEEF);
            start_vec(tbl[i].vx, tbl[i].vy, tbl[i].vz,
                      tbl[i].ex, tbl[i].ey, tbl[i].ez,
                      tbl[i].wx, tbl[i].wy, tbl[i].wz, 1'b1, 1'b0, 4'd0, '0);
            wait_done(20, "table");
        end

        // busy protection: STARTER and write during computation are dropped
        load_all(ident());
        write_coef(4'd0, 32'h0002_0000);
        start_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                  32'h0002_0000, 32'h0002_0000, 32'h0003_0000,
                  32'h0002_0000, 32'h0002_0000, 32'h0003_0000, 1'b1, 1'b0, 4'd0, '0);
        repeat (3) tick();
        STARTER = 1'b1; M_WE = 1'b1; M_ADDR = 4'd0; M_DATA = 32'h0;
        tick();
        STARTER = 1'b0; M_WE = 1'b0;
        wait_done(20, "busy_prot");
        // back-to-back in the DONE cycle, m00 still 2.0
        start_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                  32'h0002_0000, 32'h0002_0000, 32'h0003_0000,
                  32'h0002_0000, 32'h0002_0000, 32'h0003_0000, 1'b1, 1'b0, 4'd0, '0);
        wait_done(20, "b2b");
        // write on the accepting edge: applied, but this vertex sees 2.0
        start_vec(32'h0001_0000, 32'h0, 32'h0,
                  32'h0002_0000, 32'h0, 32'h0,
                  32'h0002_0000, 32'h0, 32'h0, 1'b1, 1'b1, 4'd0, 32'h0003_0000);
        wait_done(20, "same_edge");
        start_vec(32'h0001_0000, 32'h0, 32'h0,
                  32'h0003_0000, 32'h0, 32'h0,
                  32'h0003_0000, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, '0);
        wait_done(20, "after_same_edge");
        write_coef(4'd0, 32'h0);
        start_vec(32'h0001_0000, 32'h0, 32'h0,
                  32'h0, 32'h0, 32'h0,
                  32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, '0);
        wait_done(20, "idle_write");

        // reset in cycle 6 of a computation
        write_coef(4'd0, 32'h0002_0000);
        start_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                  '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 4'd0, '0);
        repeat (5) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("midrst_busy", W'(busy_s), 32'd0);
        chk("midrst_done", W'(done_s), 32'd0);
        chk("midrst_newx", newx_s, 32'd0);
        chk("midrst_newy", newy_s, 32'd0);
        chk("midrst_newz", newz_s, 32'd0);
        repeat (20) tick();
        start_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                  32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                  32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b1, 1'b0, 4'd0, '0);
        wait_done(20, "post_reset");

        repeat (4) tick();
        chk("scoreboard_empty", W'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
